// File: rtl/fetch_pkg.sv
// Shared constants, buffer-entry type and address helper for the fetch stage.
package fetch_pkg;

   localparam int          INSN_W       = 32;
   localparam int          ADDR_W_DEF   = 10;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

   typedef struct packed {
      logic [31:0]       pc;
      logic [INSN_W-1:0] inst;
   } fetch_entry_t;

   // Word-align an address and confine it to the instruction-memory window.
   function automatic logic [31:0] word_addr(input logic [31:0] addr, input int addr_w);
      logic [31:0] mask;
      for (int i = 0; i < 32; i++) begin
         mask[i] = (i < addr_w) ? 1'b1 : 1'b0;
      end
      return addr & mask & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect input and decode handshake.
interface fetch_if;
   import fetch_pkg::*;

   logic [31:0]       imem_addr;
   logic              imem_memW;
   logic [INSN_W-1:0] imem_rdata;
   logic              redir_valid;
   logic [31:0]       redir_pc;
   logic              dec_valid;
   logic              dec_ready;
   logic [INSN_W-1:0] dec_inst;
   logic [31:0]       dec_pc;

   modport master (
      output imem_addr, imem_memW, dec_valid, dec_inst, dec_pc,
      input  imem_rdata, redir_valid, redir_pc, dec_ready
   );

   modport slave (
      input  imem_addr, imem_memW, dec_valid, dec_inst, dec_pc,
      output imem_rdata, redir_valid, redir_pc, dec_ready
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO of fetched {pc, inst} entries with synchronous flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         flush,
   input  fetch_entry_t                 din,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fetch_entry_t                 head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   fetch_entry_t    mem_r [DEPTH];
   logic [PW-1:0]   rd_ptr_r;
   logic [PW-1:0]   wr_ptr_r;
   logic [CW-1:0]   count_r;
   logic            push_s;
   logic            pop_s;

   // Protect storage against overflow/underflow even if the caller misbehaves.
   always_comb begin
      pop_s  = pop && (count_r != {CW{1'b0}});
      push_s = push && ((count_r < CW'(DEPTH)) || pop_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (flush) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign count = count_r;
   assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirect handling and a decoupling buffer to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF,
   parameter int          ADDR_W   = ADDR_W_DEF,
   parameter int          DEPTH    = 2
) (
   input  logic   clk,
   input  logic   rst,
   fetch_if.master fif,
   output logic   fetch_fault
);

   localparam int CW = $clog2(DEPTH+1);

   logic [31:0]     pc_r;
   logic [31:0]     pc_nxt_s;
   logic [CW-1:0]   count_s;
   fetch_entry_t    head_s;
   fetch_entry_t    entry_s;
   logic            pop_s;
   logic            push_s;
   logic            halt_s;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_r;

   // Sticky trap on a misaligned redirect; only reset clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         fault_r <= 1'b0;
      end else if (fif.redir_valid && (fif.redir_pc[1:0] != 2'b00)) begin
         fault_r <= 1'b1;
      end else begin
         fault_r <= fault_r;
      end
   end

   assign halt_s      = fault_r;
   assign fetch_fault = fault_r;
`else
   assign halt_s      = 1'b0;
   assign fetch_fault = 1'b0;
`endif

   // Handshake, push decision and next PC; a redirect overrides sequential fetch.
   always_comb begin
      pop_s   = fif.dec_valid && fif.dec_ready;
      push_s  = ((count_s < CW'(DEPTH)) || pop_s) && !fif.redir_valid && !halt_s;
      entry_s = '{pc: pc_r, inst: fif.imem_rdata};
      if (fif.redir_valid) begin
         pc_nxt_s = word_addr(fif.redir_pc, ADDR_W);
      end else if (push_s) begin
         pc_nxt_s = word_addr(pc_r + 32'd4, ADDR_W);
      end else begin
         pc_nxt_s = pc_r;
      end
   end

   // Program counter, always held word-aligned inside the memory window.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_r <= word_addr(RESET_PC, ADDR_W);
      end else begin
         pc_r <= pc_nxt_s;
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .flush (fif.redir_valid),
      .din   (entry_s),
      .count (count_s),
      .head  (head_s)
   );

   assign fif.imem_addr = pc_r;
   assign fif.imem_memW = 1'b0;
   assign fif.dec_valid = (count_s != {CW{1'b0}});
   assign fif.dec_inst  = head_s.inst;
   assign fif.dec_pc    = head_s.pc;

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
- REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
- REQ-002 SHALL have parameter ADDR_W, default 10: byte-address width of instruction memory (2^10 bytes).
- REQ-003 SHALL have parameter DEPTH, default 2: fetch buffer entries, power of two, >=2.
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
- REQ-005 SHALL have port rst, input, 1: synchronous, active-high reset.
- REQ-006 SHALL have port imem_addr, output, 32: byte address to instruction memory read port (combinational read, data valid same cycle).
- REQ-007 SHALL have port imem_memW, output, 1: instruction memory write enable, constant 0.
- REQ-008 SHALL have port imem_rdata, input, 32: instruction word returned for imem_addr.
- REQ-009 SHALL have port redir_valid, input, 1: redirect request (branch/jump) this cycle.
- REQ-010 SHALL have port redir_pc, input, 32: redirect target byte address.
- REQ-011 SHALL have port dec_valid, output, 1: dec_inst/dec_pc hold a valid instruction.
- REQ-012 SHALL have port dec_ready, input, 1: decode accepts this cycle.
- REQ-013 SHALL have port dec_inst, output, 32: instruction word at buffer head.
- REQ-014 SHALL have port dec_pc, output, 32: byte address of dec_inst.
- REQ-015 SHALL have port fetch_fault, output, 1: sticky misaligned-redirect flag (see Configuration).

Function
- REQ-016 SHALL drive imem_addr = {pc[31:2], 2'b00} every cycle, pc masked to ADDR_W bits (upper bits zero).
- REQ-017 SHALL push {pc, imem_rdata} into the buffer and advance pc by 4 when push_ok = (count < DEPTH or pop) and no redirect and not halted.
- REQ-018 SHALL wrap pc from 2^ADDR_W-4 to 0.
- REQ-019 SHALL pop the head when dec_valid && dec_ready; pop and push in the same cycle keep count unchanged.
- REQ-020 SHALL assert dec_valid iff count != 0; dec_inst/dec_pc SHALL be the registered head entry (no combinational path from imem_rdata).
- REQ-021 SHALL hold dec_inst/dec_pc stable while dec_valid && !dec_ready.
- REQ-022 SHALL, on redir_valid, clear the buffer (count=0), load pc with redir_pc, and suppress the push that cycle; a same-cycle dec handshake SHALL count as transferred.
- REQ-023 SHALL give 1-cycle fetch latency: address presented in cycle N appears on dec_* in cycle N+1 when the buffer was empty.
- REQ-024 SHALL sustain one instruction per cycle while dec_ready is held high.
- REQ-025 SHALL, when full and dec_ready low, hold pc and imem_addr unchanged.

Reset
- REQ-026 SHALL on rst set pc=RESET_PC, count=0, dec_valid=0, dec_inst=0, dec_pc=0, fetch_fault=0.
- REQ-027 SHALL give rst priority over redir_valid and all handshakes; reset mid-stream SHALL discard buffered entries.
- REQ-028 SHALL begin fetching at RESET_PC in the first cycle after rst deasserts.

Configuration
- REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined, on redir_valid with redir_pc[1:0]!=0 set fetch_fault=1, flush buffer, and halt fetch (no pushes) until rst.
- REQ-030 SHALL, without FETCH_MISALIGN_TRAP_EN, ignore redir_pc[1:0] (cleared), never halt, and tie fetch_fault to 0.

Structure
- REQ-031 SHALL take INSN_W (32), default ADDR_W and RESET_PC constants, and the buffer-entry typedef {pc, inst} from shared package fetch_pkg.
- REQ-032 SHALL implement the buffer as sub-module fetch_fifo (parameter DEPTH, push/pop/flush, count, head), synchronous flush.

Verification
Memory preloaded: word at byte address i = {i+3, i+2, i+1, i} (e.g. addr 0 -> 32'h03020100, addr 4 -> 32'h07060504).
- REQ-033 SHALL check reset release, dec_ready=1: cycle 1 dec_pc=0/dec_inst=32'h03020100, cycle 2 dec_pc=4/32'h07060504, one per cycle.
- REQ-034 SHALL check dec_ready=0 for 5 cycles: count saturates at 2, imem_addr frozen at 8, dec_inst stays 32'h03020100; on release, order 0,4,8 with no loss or duplicates.
- REQ-035 SHALL check redirect to 32'h40 while buffer full: next cycle dec_valid=0 (flushed), following cycle dec_pc=32'h40, dec_inst=32'h43424140.
- REQ-036 SHALL check wrap: redirect to 32'h3FC, stream shows dec_pc 32'h3FC (32'hFFFEFDFC) then 0 (32'h03020100).
- REQ-037 SHALL check redirect to 32'h42: with FETCH_MISALIGN_TRAP_EN fetch_fault=1 and dec_valid stays 0 until rst; without it, dec_pc=32'h40.
- REQ-038 SHALL check rst asserted mid-stream with 2 entries buffered: next cycle dec_valid=0, imem_addr=RESET_PC, fetch_fault=0.
